// File: rtl/if_inst_prefetch_fifo_if.sv
// Handshake bundle between the instruction prefetch buffer and its neighbours.
// The master side is the fetch producer plus the decode consumer.
// The slave side is the buffer itself.
interface if_inst_prefetch_fifo_if #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          push_valid;
   logic [AW-1:0] push_pc;
   logic [DW-1:0] push_inst;
   logic          push_ready;
   logic          pop_valid;
   logic [AW-1:0] pop_pc;
   logic [DW-1:0] pop_inst;
   logic          pop_ready;
   logic [CW-1:0] count;

   modport master (
      output push_valid, push_pc, push_inst, pop_ready,
      input  push_ready, pop_valid, pop_pc, pop_inst, count
   );

   modport slave (
      input  push_valid, push_pc, push_inst, pop_ready,
      output push_ready, pop_valid, pop_pc, pop_inst, count
   );
endinterface

// File: rtl/if_inst_prefetch_fifo.sv
// Instruction prefetch buffer between the bus fetch master and the IF/ID register.
// It holds {pc, instruction} pairs in strict FIFO order, and a flush empties it.
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, a push into an
// empty buffer is forwarded straight to the pop side in the same cycle.
module if_inst_prefetch_fifo #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int DEPTH = 4
) (
   input logic                     clk,
   input logic                     rst,
   input logic                     flush,
   if_inst_prefetch_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] pc_mem   [DEPTH];
   logic [DW-1:0] inst_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   logic full;
   logic empty;
   logic bypass;
   logic push_fire;
   logic pop_fire;
   logic do_write;
   logic do_read;

   // Handshake decode: decides what is offered, accepted, stored and retired this cycle
   always_comb begin
      full          = (count_q == CW'(DEPTH));
      empty         = (count_q == '0);
      bypass        = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      bypass        = empty && bus.push_valid && !flush;
`endif
      bus.push_ready = !full && !flush;
      bus.pop_valid  = (!empty || bypass) && !flush;
      bus.pop_pc     = '0;
      bus.pop_inst   = '0;
      if (bus.pop_valid) begin
         if (bypass) begin
            bus.pop_pc   = bus.push_pc;
            bus.pop_inst = bus.push_inst;
         end else begin
            bus.pop_pc   = pc_mem[rd_ptr];
            bus.pop_inst = inst_mem[rd_ptr];
         end
      end
      push_fire = bus.push_valid && bus.push_ready;
      pop_fire  = bus.pop_valid && bus.pop_ready;
      do_write  = push_fire && !(bypass && bus.pop_ready);
      do_read   = pop_fire && !bypass;
      bus.count = count_q;
   end

   // Pointer and occupancy tracking; reset wins over flush, flush wins over traffic
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (do_write && !do_read) begin
            count_q <= count_q + CW'(1);
         end else if (!do_write && do_read) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // Storage write; the array carries no reset because stale slots are never exposed
   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         pc_mem[wr_ptr]   <= bus.push_pc;
         inst_mem[wr_ptr] <= bus.push_inst;
      end
   end
endmodule

// File: tb/tb_if_inst_prefetch_fifo.sv
// Self-checking bench for the instruction prefetch buffer.
// A queue of {pc, inst} pairs models the buffer; the queue is compared against
// the outputs every cycle under directed scenarios followed by random traffic.
module tb_if_inst_prefetch_fifo;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   int checks   = 0;
   int failures = 0;

   logic [AW+DW-1:0] model [$];
   logic [AW-1:0]    next_pc;
   logic [DW-1:0]    next_inst;

   // Free-running core clock
   always #5 clk = ~clk;

   if_inst_prefetch_fifo_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

   if_inst_prefetch_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic f, input logic pv, input logic pr);
      int               n;
      logic             exp_push_ready;
      logic             exp_pop_valid;
      logic             byp;
      logic [AW+DW-1:0] head;
      logic             push_fire;
      logic             pop_fire;

      @(negedge clk);
      rst            = r;
      flush          = f;
      bus.push_valid = pv;
      bus.push_pc    = next_pc;
      bus.push_inst  = next_inst;
      bus.pop_ready  = pr;
      #1;
      n              = model.size();
      exp_push_ready = (n < DEPTH) && !f;
      byp            = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      byp            = (n == 0) && pv && !f;
`endif
      exp_pop_valid  = ((n > 0) || byp) && !f;
      head           = '0;
      if (exp_pop_valid) begin
         head = byp ? {next_pc, next_inst} : model[0];
      end
      checkOutput("count",      64'(bus.count),      64'(n));
      checkOutput("push_ready", 64'(bus.push_ready), 64'(exp_push_ready));
      checkOutput("pop_valid",  64'(bus.pop_valid),  64'(exp_pop_valid));
      checkOutput("pop_pc",     64'(bus.pop_pc),     64'(head[AW+DW-1:DW]));
      checkOutput("pop_inst",   64'(bus.pop_inst),   64'(head[DW-1:0]));

      push_fire = pv && exp_push_ready;
      pop_fire  = exp_pop_valid && pr;
      @(posedge clk);
      if (r || f) begin
         model.delete();
      end else begin
         if (pop_fire && !byp) begin
            void'(model.pop_front());
         end
         if (push_fire && !(byp && pr)) begin
            model.push_back({next_pc, next_inst});
         end
      end
      if (!r && push_fire) begin
         next_pc   = next_pc + 32'd4;
         next_inst = $urandom;
      end
   endtask

   // Directed scenarios, then random traffic, then the summary
   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      bus.push_valid = 1'b0;
      bus.push_pc    = '0;
      bus.push_inst  = '0;
      bus.pop_ready  = 1'b0;
      next_pc        = 32'h100;
      next_inst      = $urandom;
      @(posedge clk);
      model.delete();

      // Fill to full, then a held fifth push
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("held_pc", 64'(next_pc), 64'h110);

      // Drain in order
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Wrap-around with occupancy held at two
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

      // Flush with traffic at count three, then a push after the flush
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Synchronous reset mid-stream with a push pending
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Push into an empty buffer with decode ready
      next_pc = 32'h200;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
